// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-unit result FIFOs feeding one register-file write port through a round-robin grant.
// Optional feature macro: WB_BYPASS_EN (an empty FIFO may forward its incoming result straight to writeback).

package wb_arbiter_pkg;
  typedef struct packed {
    logic        instruction_valid;
    logic        register_write;
    logic [4:0]  rd;
    logic [31:0] exe_result;
  } exe_wb_inf_t;
endpackage

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_UNITS    = 3,
  parameter int FIFO_DEPTH   = 4,
  parameter int STALL_MARGIN = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  exe_wb_inf_t [NUM_UNITS-1:0] exe_wb_inf,
  output logic [NUM_UNITS-1:0]        unit_stall,
  output logic                        rf_wr_en,
  output logic [4:0]                  rf_wr_addr,
  output logic [31:0]                 rf_wr_data,
  output logic                        overflow_err
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int IDX_W   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int ENTRY_W = 37;
  localparam logic [CNT_W-1:0] STALL_LEVEL = CNT_W'(FIFO_DEPTH - STALL_MARGIN);
  localparam logic [CNT_W-1:0] FULL_LEVEL  = CNT_W'(FIFO_DEPTH);

  logic [NUM_UNITS-1:0] push_req;
  logic [NUM_UNITS-1:0] fifo_empty;
  logic [NUM_UNITS-1:0] fifo_full;
  logic [NUM_UNITS-1:0] req;
  logic [NUM_UNITS-1:0] grant;
  logic [NUM_UNITS-1:0] pop;
  logic [NUM_UNITS-1:0] push;
  logic [NUM_UNITS-1:0] drop;
  logic [ENTRY_W-1:0]   cand_entry [NUM_UNITS];

  logic [IDX_W-1:0]     last_grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_any;
  logic [ENTRY_W-1:0]   grant_entry;
  int                   search_idx;

  for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [ENTRY_W-1:0] in_entry;
    logic               bypass;

    // Stores, branches without link and x0 writes never occupy a slot.
    assign push_req[gi]   = exe_wb_inf[gi].instruction_valid & exe_wb_inf[gi].register_write &
                            (exe_wb_inf[gi].rd != 5'd0);
    assign in_entry       = {exe_wb_inf[gi].rd, exe_wb_inf[gi].exe_result};
    assign fifo_empty[gi] = (count == '0);
    assign fifo_full[gi]  = (count == FULL_LEVEL);
    assign unit_stall[gi] = (count >= STALL_LEVEL);
    assign pop[gi]        = grant[gi] & ~fifo_empty[gi];

`ifdef WB_BYPASS_EN
    assign req[gi]        = ~fifo_empty[gi] | push_req[gi];
    assign cand_entry[gi] = fifo_empty[gi] ? in_entry : mem[rd_ptr];
    assign bypass         = grant[gi] & fifo_empty[gi];
`else
    assign req[gi]        = ~fifo_empty[gi];
    assign cand_entry[gi] = mem[rd_ptr];
    assign bypass         = 1'b0;
`endif

    // A full FIFO still accepts a push when its head leaves in the same cycle.
    assign push[gi] = push_req[gi] & ~bypass & (~fifo_full[gi] | pop[gi]);
    assign drop[gi] = push_req[gi] & ~bypass & fifo_full[gi] & ~pop[gi];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[gi]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[gi])  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CNT_W'(push[gi]) - CNT_W'(pop[gi]);
      end
    end

    always_ff @(posedge clk) begin
      if (push[gi]) mem[wr_ptr] <= in_entry;
    end
  end

  // Round-robin: search begins one past the last granted unit.
  always_comb begin
    grant_any  = 1'b0;
    grant_idx  = last_grant;
    grant      = '0;
    search_idx = 0;
    for (int k = 1; k <= NUM_UNITS; k++) begin
      search_idx = (int'(last_grant) + k) % NUM_UNITS;
      if (!grant_any && req[search_idx]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(search_idx);
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
    grant_entry = cand_entry[grant_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant   <= IDX_W'(NUM_UNITS - 1);
      rf_wr_en     <= 1'b0;
      rf_wr_addr   <= '0;
      rf_wr_data   <= '0;
      overflow_err <= 1'b0;
    end else begin
      rf_wr_en <= grant_any;
      if (grant_any) begin
        last_grant <= grant_idx;
        rf_wr_addr <= grant_entry[36:32];
        rf_wr_data <= grant_entry[31:0];
      end
      if (|drop) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter at default parameters (bypass disabled).
`timescale 1ns/1ps
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  exe_wb_inf_t [2:0] exe_wb_inf;
  logic [2:0]        unit_stall;
  logic              rf_wr_en;
  logic [4:0]        rf_wr_addr;
  logic [31:0]       rf_wr_data;
  logic              overflow_err;

  int checks = 0;
  int errors = 0;

  // Expected per-unit write sequence: {rd, data}
  logic [36:0] exp_mem [3][64];
  int          exp_wr [3];
  int          exp_rd [3];
  int          writes;
  int          rr_unit;
  int          rr_checks_left;

  wb_arbiter #(
    .NUM_UNITS   (3),
    .FIFO_DEPTH  (4),
    .STALL_MARGIN(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .exe_wb_inf  (exe_wb_inf),
    .unit_stall  (unit_stall),
    .rf_wr_en    (rf_wr_en),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    exe_wb_inf = '0;
  endtask

  task automatic model_reset();
    for (int u = 0; u < 3; u++) begin
      exp_wr[u] = 0;
      exp_rd[u] = 0;
    end
    writes = 0;
    rr_checks_left = 0;
    rr_unit = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    model_reset();
    step();
    step();
    rst = 1'b0;
  endtask

  // Data tag carries the unit number in bits [9:8] and a sequence number in [7:0].
  task automatic push_unit(input int u);
    logic [4:0]  rd;
    logic [31:0] data;
    rd   = 5'(u * 10 + exp_wr[u] % 10 + 1);
    data = 32'hD000_0000 | 32'(u << 8) | 32'(exp_wr[u]);
    exe_wb_inf[u] = '{1'b1, 1'b1, rd, data};
    exp_mem[u][exp_wr[u]] = {rd, data};
    exp_wr[u]++;
  endtask

  task automatic sample_wb();
    int u;
    logic [63:0] exp_entry;
    if (rf_wr_en) begin
      u = int'(rf_wr_data[9:8]);
      writes++;
      $display("wb write: unit %0d addr %0d data %08h", u, rf_wr_addr, rf_wr_data);
      if (rr_checks_left > 0) begin
        check("rr_order", 64'(u), 64'(rr_unit));
        rr_unit = (rr_unit + 1) % 3;
        rr_checks_left--;
      end
      if (u <= 2 && exp_rd[u] < exp_wr[u]) begin
        exp_entry = 64'(exp_mem[u][exp_rd[u]]);
        exp_rd[u]++;
      end else begin
        exp_entry = 'x;
      end
      check("wb_entry", 64'({rf_wr_addr, rf_wr_data}), exp_entry);
    end
  endtask

  task automatic drain(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      sample_wb();
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();
    step();
    step();

    // Reset state
    check("rst_en", 64'(rf_wr_en), 64'd0);
    check("rst_addr", 64'(rf_wr_addr), 64'd0);
    check("rst_data", 64'(rf_wr_data), 64'd0);
    check("rst_stall", 64'(unit_stall), 64'd0);
    check("rst_ovf", 64'(overflow_err), 64'd0);
    rst = 1'b0;

    // Single ALU result: visible two cycles after it is presented
    exe_wb_inf[0] = '{1'b1, 1'b1, 5'd5, 32'hDEADBEEF};
    step();
    check("t1_en_c1", 64'(rf_wr_en), 64'd0);
    clear_inputs();
    step();
    check("t1_en_c2", 64'(rf_wr_en), 64'd1);
    check("t1_addr", 64'(rf_wr_addr), 64'd5);
    check("t1_data", 64'(rf_wr_data), 64'hDEADBEEF);
    step();
    check("t1_en_c3", 64'(rf_wr_en), 64'd0);
    check("t1_addr_hold", 64'(rf_wr_addr), 64'd5);
    check("t1_data_hold", 64'(rf_wr_data), 64'hDEADBEEF);
    for (int c = 0; c < 3; c++) begin
      step();
      check("t1_single_strobe", 64'(rf_wr_en), 64'd0);
    end

    // Non-writing results are discarded
    exe_wb_inf[0] = '{1'b1, 1'b1, 5'd0, 32'h1111_1111};
    exe_wb_inf[1] = '{1'b1, 1'b0, 5'd3, 32'h2222_2222};
    exe_wb_inf[2] = '{1'b1, 1'b0, 5'd0, 32'h3333_3333};
    for (int c = 0; c < 6; c++) begin
      step();
      check("t2_no_write", 64'(rf_wr_en), 64'd0);
      check("t2_no_stall", 64'(unit_stall), 64'd0);
    end
    clear_inputs();
    step();
    check("t2_no_write_after", 64'(rf_wr_en), 64'd0);
    check("t2_addr_hold", 64'(rf_wr_addr), 64'd5);

    // All units stream (honouring stall): round-robin 0,1,2,... and per-unit order
    do_reset();
    rr_unit = 0;
    rr_checks_left = 9;
    for (int c = 0; c < 12; c++) begin
      sample_wb();
      if (c == 1) check("t3_stall_e1", 64'(unit_stall), 64'b000);
      if (c == 2) check("t3_stall_e2", 64'(unit_stall), 64'b110);
      if (c == 3) check("t3_stall_e3", 64'(unit_stall), 64'b101);
      for (int u = 0; u < 3; u++) begin
        if (!unit_stall[u]) push_unit(u);
        else exe_wb_inf[u] = '0;
      end
      step();
    end
    clear_inputs();
    drain(30);
    check("t3_rr_done", 64'(rr_checks_left), 64'd0);
    check("t3_all_written", 64'(writes), 64'(exp_wr[0] + exp_wr[1] + exp_wr[2]));
    check("t3_no_ovf", 64'(overflow_err), 64'd0);
    check("t3_stall_idle", 64'(unit_stall), 64'd0);

    // Ignore stall: first drop happens at the 6th edge (unit 2), flag is sticky
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c == 5) check("t4_ovf_before", 64'(overflow_err), 64'd0);
      if (c >= 6) check("t4_ovf_set", 64'(overflow_err), 64'd1);
      for (int u = 0; u < 3; u++) push_unit(u);
      step();
    end
    clear_inputs();
    for (int c = 0; c < 8; c++) step();
    check("t4_ovf_sticky", 64'(overflow_err), 64'd1);

    // LSU FIFO full, then push and pop in the same cycle
    do_reset();
    check("t5_ovf_cleared", 64'(overflow_err), 64'd0);
    for (int c = 0; c < 7; c++) begin
      sample_wb();
      if (c == 5) check("t5_stall_full", 64'(unit_stall), 64'b111);
      if (c == 6) begin
        check("t5_stall_after", 64'(unit_stall), 64'b111);
        check("t5_no_ovf", 64'(overflow_err), 64'd0);
      end
      clear_inputs();
      if (c < 5) begin
        for (int u = 0; u < 3; u++) push_unit(u);
      end else if (c == 5) begin
        push_unit(1);
      end
      step();
    end
    clear_inputs();
    drain(30);
    check("t5_all_written", 64'(writes), 64'd16);
    check("t5_lsu_drained", 64'(exp_rd[1]), 64'd6);
    check("t5_no_ovf_end", 64'(overflow_err), 64'd0);

    // Asynchronous reset with entries buffered
    do_reset();
    for (int u = 0; u < 3; u++) push_unit(u);
    step();
    for (int u = 0; u < 3; u++) push_unit(u);
    step();
    clear_inputs();
    check("t6_pre_en", 64'(rf_wr_en), 64'd1);
    check("t6_pre_stall", 64'(unit_stall), 64'b110);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_en", 64'(rf_wr_en), 64'd0);
    check("t6_rst_addr", 64'(rf_wr_addr), 64'd0);
    check("t6_rst_data", 64'(rf_wr_data), 64'd0);
    check("t6_rst_stall", 64'(unit_stall), 64'd0);
    check("t6_rst_ovf", 64'(overflow_err), 64'd0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      check("t6_no_write", 64'(rf_wr_en), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
